pyramid_feeder: RTL and testbench
=================================

# pyramid_feeder

Streams a stored source frame, pixel by pixel in raster order, into the Gaussian pyramid builder's input port. It reads the frame buffer through a fixed-latency BRAM read port and presents each pixel with its linear address on a valid/ready stream. It asserts a level `data_done_out` once the whole frame has been accepted. It sits between the capture frame buffer (UART/camera side) and `gaussian_pyramid`.

## Interface
- `WIDTH`, 128, frame width in pixels
- `HEIGHT`, 128, frame height in pixels
- `BIT_DEPTH`, 8, bits per pixel
- `READ_LATENCY`, 2, cycles from `bram_en_out`/`bram_addr_out` to valid `bram_data_in`
- `FIFO_DEPTH`, 4, output buffer entries; must be ≥ `READ_LATENCY`+1
- Derived: `ADDR_W = $clog2(WIDTH*HEIGHT)` (14 at defaults)

Ports:
- `clk_in` in 1: single clock for the block
- `rst_in` in 1: asynchronous, active-high reset
- `start_in` in 1: one-cycle pulse that starts a frame transfer
- `bram_en_out` out 1: read enable to the frame buffer
- `bram_addr_out` out ADDR_W: read address
- `bram_data_in` in BIT_DEPTH: read data, valid `READ_LATENCY` cycles after the enable
- `data_out` out BIT_DEPTH: pixel value
- `data_addr_out` out ADDR_W: linear address of `data_out`, equal to y*WIDTH+x
- `data_valid_out` out 1: stream valid
- `data_ready_in` in 1: stream ready from the consumer
- `data_done_out` out 1: level signal; the whole frame has been accepted
- `busy_out` out 1: a transfer is in progress
- `error_out` out 1: one-cycle pulse when `start_in` arrives while busy

## Operation
- FSM states: IDLE, STREAM, DRAIN, DONE.
  - IDLE → STREAM on `start_in`. On entry the read address is cleared to 0, `data_done_out` is cleared, and the credit counter is cleared.
  - STREAM: the block issues one read per cycle when in-flight reads plus FIFO occupancy is less than `FIFO_DEPTH`. After the read of address WIDTH*HEIGHT−1 has been issued, the FSM moves to DRAIN.
  - DRAIN: no further reads are issued. The FSM moves to DONE on the handshake of the last pixel.
  - DONE: `data_done_out`=1. Returns to IDLE in the same cycle; `data_done_out` stays high until the next accepted `start_in`.
- A read-tag shift register of length `READ_LATENCY` tracks in-flight reads. Each returning word is written into `feeder_fifo` together with its address.
- Handshake rules:
  - A transfer occurs when `data_valid_out` && `data_ready_in`.
  - `data_out`, `data_addr_out` and `data_valid_out` hold stable while valid is high and ready is low.
  - Pixels are never dropped or duplicated.
  - Valid does not depend combinationally on ready.
- `busy_out` = (state ≠ IDLE) or FIFO not empty.
- `start_in` while busy is ignored and `error_out` pulses high for 1 cycle.
- Arithmetic: the read address counter is ADDR_W bits and stops at WIDTH*HEIGHT−1; it never wraps during a frame.
- Reset, including reset mid-frame: every output goes to 0 asynchronously, the FSM goes to IDLE, the FIFO is flushed, and in-flight reads are discarded.

## Timing
- Reset values: `bram_en_out`=0, `bram_addr_out`=0, `data_out`=0, `data_addr_out`=0, `data_valid_out`=0, `data_done_out`=0, `busy_out`=0, `error_out`=0.
- Start handshake: `start_in` is sampled at edge k.
  - `bram_en_out`=1 with address 0 during cycle k+1.
  - Data arrives in cycle k+1+`READ_LATENCY`.
  - `data_valid_out`=1 with address 0 from cycle k+2+`READ_LATENCY` (k+4 at defaults).
- Throughput: with `data_ready_in` held high, one pixel per cycle. The last pixel (address 16383) is valid at cycle k+16387 at defaults. `data_done_out` rises on the cycle after its handshake.
- Backpressure: reads stop within 1 cycle of the credit being exhausted. Streaming resumes the cycle after ready returns.

## Configuration
- `PYRAMID_FEEDER_TESTPATTERN_EN`:
  - Defined: the BRAM port is unused (`bram_en_out` tied 0) and each pixel is generated internally as (x+y) mod 2^BIT_DEPTH, with identical stream timing and handshake.
  - Undefined: pixels come from `bram_data_in`.

## Structure
- Shared package `pyramid_pkg` holds:
  - the constants `IMG_WIDTH`, `IMG_HEIGHT` and `PIX_DEPTH`
  - the `ADDR_W` function/localparam
  - the `feeder_state_t` enum
  - the pixel/address struct `pix_beat_t`
- One sub-module, `feeder_fifo`: a synchronous FIFO with parameterized depth and width that carries `pix_beat_t`, with full/empty flags and async reset.

## Test plan
- Ready tied 1, BRAM holds value addr[7:0]: start → 16384 beats, beat n has data n mod 256 and address n, first valid at k+4, done at k+16388.
- Ready toggles 1/0 pseudo-randomly: every address 0..16383 is seen exactly once in order, data stable while stalled, and at most `FIFO_DEPTH` reads are outstanding.
- Ready held 0 for 100 cycles after start: `bram_en_out` is asserted exactly 4 times, then holds 0, with no loss on release.
- `start_in` pulsed at beat 500: `error_out` pulses 1 cycle and the stream continues unaffected.
- `rst_in` asserted at beat 1000: all outputs are 0 immediately; a new start then streams from address 0.
- With `PYRAMID_FEEDER_TESTPATTERN_EN`: beat at x=3, y=2 carries 5, and `bram_en_out` is never 1.

Source files
------------

// File: rtl/pyramid_pkg.sv
// Shared types and constants for the Gaussian pyramid front end: image geometry,
// feeder FSM states and the pixel/address beat carried through the feeder FIFO.
package pyramid_pkg;

  localparam int unsigned IMG_WIDTH  = 128;
  localparam int unsigned IMG_HEIGHT = 128;
  localparam int unsigned PIX_DEPTH  = 8;

  function automatic int unsigned addr_w(input int unsigned w, input int unsigned h);
    return $clog2(w * h);
  endfunction

  localparam int unsigned ADDR_W = addr_w(IMG_WIDTH, IMG_HEIGHT);

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StDrain,
    StDone
  } feeder_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]    addr;
    logic [PIX_DEPTH-1:0] data;
  } pix_beat_t;

endpackage

// File: rtl/feeder_fifo.sv
// Small synchronous FIFO for the pyramid feeder; by default one entry holds a pix_beat_t.
// Read data is the head entry, presented directly from storage.
module feeder_fifo
  import pyramid_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = $bits(pix_beat_t)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic [CntW-1:0]  count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CntW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= (wr_ptr == PtrW'(DEPTH - 1)) ? '0 : wr_ptr + PtrW'(1);
      end
      if (do_pop) rd_ptr <= (rd_ptr == PtrW'(DEPTH - 1)) ? '0 : rd_ptr + PtrW'(1);
      if (do_push && !do_pop)      count <= count + CntW'(1);
      else if (do_pop && !do_push) count <= count - CntW'(1);
    end
  end

endmodule

// File: rtl/pyramid_feeder.sv
// Streams a stored frame in raster order from a fixed-latency BRAM port onto a valid/ready stream.
// Define PYRAMID_FEEDER_TESTPATTERN_EN to replace BRAM data with an internal (x+y) pattern.
module pyramid_feeder #(
  parameter int unsigned WIDTH        = pyramid_pkg::IMG_WIDTH,
  parameter int unsigned HEIGHT       = pyramid_pkg::IMG_HEIGHT,
  parameter int unsigned BIT_DEPTH    = pyramid_pkg::PIX_DEPTH,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned FIFO_DEPTH   = 4,
  localparam int unsigned ADDR_W      = pyramid_pkg::addr_w(WIDTH, HEIGHT)
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 start_in,
  output logic                 bram_en_out,
  output logic [ADDR_W-1:0]    bram_addr_out,
  input  logic [BIT_DEPTH-1:0] bram_data_in,
  output logic [BIT_DEPTH-1:0] data_out,
  output logic [ADDR_W-1:0]    data_addr_out,
  output logic                 data_valid_out,
  input  logic                 data_ready_in,
  output logic                 data_done_out,
  output logic                 busy_out,
  output logic                 error_out
);
  import pyramid_pkg::*;

  localparam int unsigned NPix = WIDTH * HEIGHT;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NPix - 1);
  localparam int unsigned BeatW = ADDR_W + BIT_DEPTH;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  feeder_state_t            state;
  logic [ADDR_W-1:0]        rd_addr;
  logic                     en_q;
  logic [ADDR_W-1:0]        addr_q;
  logic [READ_LATENCY-1:0]  tag_vld;
  logic [ADDR_W-1:0]        tag_addr [READ_LATENCY];
  logic [CntW-1:0]          credit;
  logic                     done_q;
  logic                     err_q;
  logic                     busy;
  logic                     issue;
  logic [ADDR_W-1:0]        issue_addr;
  logic                     push;
  logic                     pop;
  logic [BIT_DEPTH-1:0]     push_data;
  logic [ADDR_W-1:0]        push_addr;
  logic [BeatW-1:0]         wr_beat;
  logic [BeatW-1:0]         rd_beat;
  logic                     fifo_empty;
  logic                     unused_full;

  assign busy      = (state != StIdle) || !fifo_empty;
  assign pop       = !fifo_empty && data_ready_in;
  assign push      = tag_vld[READ_LATENCY-1];
  assign push_addr = tag_addr[READ_LATENCY-1];
  assign wr_beat   = {push_addr, push_data};

`ifdef PYRAMID_FEEDER_TESTPATTERN_EN
  logic unused_bram;
  assign unused_bram = ^bram_data_in;
  assign push_data   = BIT_DEPTH'((32'(push_addr) % WIDTH) + (32'(push_addr) / WIDTH));
  assign bram_en_out = 1'b0;
`else
  assign push_data   = bram_data_in;
  assign bram_en_out = en_q;
`endif

  assign bram_addr_out  = addr_q;
  assign data_out       = rd_beat[BIT_DEPTH-1:0];
  assign data_addr_out  = rd_beat[BeatW-1:BIT_DEPTH];
  assign data_valid_out = !fifo_empty;
  assign data_done_out  = done_q;
  assign busy_out       = busy;
  assign error_out      = err_q;

  // Credit counts reads from issue until their pixel is accepted; a pop this cycle frees one.
  always_comb begin
    issue      = 1'b0;
    issue_addr = rd_addr;
    case (state)
      StIdle: begin
        issue      = start_in && !busy;
        issue_addr = '0;
      end
      StStream: issue = 32'(credit) < FIFO_DEPTH + 32'(pop);
      default:  issue = 1'b0;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state   <= StIdle;
      rd_addr <= '0;
      en_q    <= 1'b0;
      addr_q  <= '0;
      credit  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      tag_vld <= '0;
      for (int i = 0; i < READ_LATENCY; i++) tag_addr[i] <= '0;
    end else begin
      en_q        <= issue;
      err_q       <= start_in && busy;
      credit      <= credit + CntW'(issue) - CntW'(pop);
      tag_vld[0]  <= en_q;
      tag_addr[0] <= addr_q;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_vld[i]  <= tag_vld[i-1];
        tag_addr[i] <= tag_addr[i-1];
      end
      if (issue) begin
        addr_q <= issue_addr;
        if (issue_addr != LastAddr) rd_addr <= issue_addr + ADDR_W'(1);
      end
      case (state)
        StIdle: begin
          if (issue) begin
            done_q <= 1'b0;
            credit <= CntW'(1);
            state  <= (issue_addr == LastAddr) ? StDrain : StStream;
          end
        end
        StStream: if (issue && issue_addr == LastAddr) state <= StDrain;
        StDrain: begin
          if (pop && data_addr_out == LastAddr) begin
            state  <= StDone;
            done_q <= 1'b1;
          end
        end
        StDone:  state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

  feeder_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BeatW)
  ) u_fifo (
    .clk     (clk_in),
    .rst     (rst_in),
    .push    (push),
    .wr_data (wr_beat),
    .pop     (pop),
    .rd_data (rd_beat),
    .full    (unused_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_pyramid_feeder.sv
// Self-checking bench for pyramid_feeder: a BRAM model returning addr[7:0], a stream model
// predicting every beat, done/busy/error levels, plus directed timing and reset checks.
module tb_pyramid_feeder;

  localparam int NPIX  = 128 * 128;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_in;
  logic        start_in;
  logic        bram_en_out;
  logic [13:0] bram_addr_out;
  logic [7:0]  bram_data_in;
  logic [7:0]  data_out;
  logic [13:0] data_addr_out;
  logic        data_valid_out;
  logic        data_ready_in;
  logic        data_done_out;
  logic        busy_out;
  logic        error_out;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  pyramid_feeder dut (
    .clk_in         (clk),
    .rst_in         (rst_in),
    .start_in       (start_in),
    .bram_en_out    (bram_en_out),
    .bram_addr_out  (bram_addr_out),
    .bram_data_in   (bram_data_in),
    .data_out       (data_out),
    .data_addr_out  (data_addr_out),
    .data_valid_out (data_valid_out),
    .data_ready_in  (data_ready_in),
    .data_done_out  (data_done_out),
    .busy_out       (busy_out),
    .error_out      (error_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame buffer: pixel value is addr[7:0], returned two cycles after the enable.
  logic        p0_v, p1_v;
  logic [13:0] p0_a, p1_a;
  always @(posedge clk) begin
    p0_v <= bram_en_out;
    p0_a <= bram_addr_out;
    p1_v <= p0_v;
    p1_a <= p0_a;
  end
  assign bram_data_in = p1_v ? p1_a[7:0] : 8'hEE;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] exp_pix(input int n);
`ifdef PYRAMID_FEEDER_TESTPATTERN_EN
    return 8'((n % 128) + (n / 128));
`else
    return 8'(n % 256);
`endif
  endfunction

  // Model state (owned by the compare process).
  int          exp_n, hs_cnt, en_cnt, start_cyc, first_valid, first_en;
  logic        done_exp, busy_exp, err_exp, leave;
  logic        prev_stall;
  logic [7:0]  prev_data;
  logic [13:0] prev_addr;
  logic [31:0] cap259;

  task automatic model_reset();
    exp_n = 0; hs_cnt = 0; en_cnt = 0; first_valid = -1; first_en = -1;
    done_exp = 0; busy_exp = 0; err_exp = 0; leave = 0; prev_stall = 0;
    cap259 = 32'hFFFF;
  endtask

  initial begin : compare
    logic hs, busy_now;
    model_reset();
    start_cyc = 0;
    forever begin
      @(negedge clk);
      if (rst_in) begin
        model_reset();
      end else begin
        check("done_level", data_done_out, done_exp);
        check("busy_level", busy_out, busy_exp);
        check("error_pulse_model", error_out, err_exp);
        if (bram_en_out) begin
          en_cnt++;
          if (first_en < 0) first_en = cyc;
          check("read_addr_seq", bram_addr_out, en_cnt - 1);
        end
`ifdef PYRAMID_FEEDER_TESTPATTERN_EN
        check("bram_en_tied0", bram_en_out, 0);
`else
        check("outstanding_le_depth", ((en_cnt - hs_cnt) <= DEPTH), 1);
`endif
        if (prev_stall) begin
          check("stall_valid_hold", data_valid_out, 1);
          check("stall_data_hold", data_out, prev_data);
          check("stall_addr_hold", data_addr_out, prev_addr);
        end
        if (data_valid_out && first_valid < 0) first_valid = cyc;
        hs = data_valid_out && data_ready_in;
        if (hs) begin
          check("beat_addr", data_addr_out, exp_n);
          check("beat_data", data_out, exp_pix(exp_n));
          if (data_addr_out == 14'd259) cap259 = 32'(data_out);
          hs_cnt++;
          exp_n++;
        end
        prev_stall = data_valid_out && !data_ready_in;
        prev_data  = data_out;
        prev_addr  = data_addr_out;
        // Predict next cycle's levels.
        busy_now = busy_exp;
        err_exp  = start_in && busy_now;
        if (leave) begin
          busy_exp = 0;
          leave    = 0;
        end
        if (start_in && !busy_now) begin
          busy_exp = 1; done_exp = 0; exp_n = 0; hs_cnt = 0; en_cnt = 0;
          first_valid = -1; first_en = -1; cap259 = 32'hFFFF;
          start_cyc = cyc + 1;
        end
        if (hs && exp_n == NPIX) begin
          done_exp = 1;
          leave    = 1;
        end
      end
    end
  end

  task automatic pulse_start();
    start_in = 1'b1;
    @(posedge clk); #1;
    start_in = 1'b0;
  endtask

  task automatic wait_beats(input int n);
    int budget;
    budget = 20000;
    while (exp_n < n && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    check("reach_beat_in_time", (exp_n >= n), 1);
  endtask

  task automatic run_to_done(input bit rnd);
    int budget;
    budget = 40000;
    while (!data_done_out && budget > 0) begin
      if (rnd) data_ready_in = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      budget--;
    end
    check("frame_done_in_time", data_done_out, 1);
    data_ready_in = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_bram_en"}, bram_en_out, 0);
    check({tag, "_bram_addr"}, bram_addr_out, 0);
    check({tag, "_data"}, data_out, 0);
    check({tag, "_data_addr"}, data_addr_out, 0);
    check({tag, "_valid"}, data_valid_out, 0);
    check({tag, "_done"}, data_done_out, 0);
    check({tag, "_busy"}, busy_out, 0);
    check({tag, "_error"}, error_out, 0);
  endtask

  initial begin : driver
    rst_in = 1'b1; start_in = 1'b0; data_ready_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_in = 1'b0;
    @(posedge clk); #1;

    // Frame 1: ready high, extra start at beat 500.
    data_ready_in = 1'b1;
    pulse_start();
    wait_beats(500);
    pulse_start();
    check("busy_start_error", error_out, 1);
    @(posedge clk); #1;
    check("error_one_cycle", error_out, 0);
    run_to_done(1'b0);
    check("done_rise_ofs", cyc - start_cyc, 16387);
    check("first_valid_ofs", first_valid - start_cyc, 3);
    check("beats_total", exp_n, NPIX);
    check("pixel_x3_y2", cap259, exp_pix(259));
`ifdef PYRAMID_FEEDER_TESTPATTERN_EN
    check("pixel_x3_y2_lit", cap259, 5);
`else
    check("pixel_x3_y2_lit", cap259, 3);
    check("first_en_ofs", first_en - start_cyc, 0);
`endif

    // Frame 2: ready held low 100 cycles, then random backpressure.
    @(posedge clk); #1;
    data_ready_in = 1'b0;
    pulse_start();
    repeat (100) @(posedge clk);
    #1;
    check("stalled_valid", data_valid_out, 1);
    check("stalled_addr", data_addr_out, 0);
`ifndef PYRAMID_FEEDER_TESTPATTERN_EN
    check("stall_read_count", en_cnt, 4);
    check("stall_bram_en_low", bram_en_out, 0);
`endif
    run_to_done(1'b1);
    check("beats_total_rand", exp_n, NPIX);

    // Frame 3: reset at beat 1000, then a clean frame.
    @(posedge clk); #1;
    pulse_start();
    wait_beats(1000);
    #2 rst_in = 1'b1;
    #1 check_all_zero("midreset");
    @(posedge clk); #1;
    rst_in = 1'b0;
    @(posedge clk); #1;
    pulse_start();
    run_to_done(1'b0);
    check("restart_first_valid_ofs", first_valid - start_cyc, 3);
    check("beats_total_restart", exp_n, NPIX);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
